// File: rtl/riscv_cache_pkg.sv
// Shared cache types and widths, used by the refill controller and the cache array.
package riscv_cache_pkg;

    localparam int ADDR_WIDTH          = 32;
    localparam int DATA_WIDTH          = 32;
    localparam int TAG_WIDTH           = 24;
    localparam int CACHE_ADDRESS_WIDTH = 4;
    localparam int LINE_WORDS          = 4;
    localparam int CACHE_DATA_WIDTH    = 1 + TAG_WIDTH + LINE_WORDS * DATA_WIDTH;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        FILL,
        DRAIN
    } refill_state_t;

    // word[0] sits in the least significant bits; slots are by block offset
    typedef struct packed {
        logic                                 valid;
        logic [TAG_WIDTH-1:0]                 tag;
        logic [LINE_WORDS-1:0][DATA_WIDTH-1:0] word;
    } cache_entry_t;

endpackage

// File: rtl/cache_refill_ctrl.sv
// Read-miss refill: fetches the 4-word line critical word first, forwards the
// critical word early, then presents the whole entry for one array write.
//
// state | meaning
// IDLE  | no refill; miss_ack follows miss_req
// REQ   | mem_req raised for the next word until granted
// WAIT  | granted word outstanding; waiting for its read data
// FILL  | complete entry on fill_line until the cache takes it
// DRAIN | flushed with a read still outstanding; discard that one response
module cache_refill_ctrl
    import riscv_cache_pkg::*;
(
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           miss_req,
    input  logic [ADDR_WIDTH-1:0]          miss_addr,
    output logic                           miss_ack,
    output logic                           busy,
    input  logic                           flush,
    output logic                           mem_req,
    output logic [ADDR_WIDTH-1:0]          mem_addr,
    input  logic                           mem_gnt,
    input  logic                           mem_rvalid,
    input  logic [DATA_WIDTH-1:0]          mem_rdata,
    output logic                           crit_valid,
    output logic [DATA_WIDTH-1:0]          crit_data,
    output logic                           fill_valid,
    output logic [CACHE_ADDRESS_WIDTH-1:0] fill_set,
    output logic [CACHE_DATA_WIDTH-1:0]    fill_line,
    input  logic                           fill_ready
);

    refill_state_t state, state_nxt;

    logic [TAG_WIDTH-1:0]                  tag_q;
    logic [CACHE_ADDRESS_WIDTH-1:0]        set_q;
    logic [1:0]                            start_q;
    logic [1:0]                            cnt_q;
    logic [LINE_WORDS-1:0][DATA_WIDTH-1:0] buf_q;
    logic                                  crit_valid_q;
    logic [DATA_WIDTH-1:0]                 crit_data_q;

    logic [1:0]   slot;
    logic         accept;
    logic         capture;
    cache_entry_t entry;
    logic         byte_offset_unused;

    // offset of the word in flight; 2-bit add gives the mod-4 wrap
    assign slot    = start_q + cnt_q;
    assign accept  = (state == IDLE) && miss_req;
    assign capture = (state == WAIT) && mem_rvalid && !flush;
    assign entry   = {1'b1, tag_q, buf_q};
    assign byte_offset_unused = ^miss_addr[1:0];

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // next state and acknowledge; flush overrides every other event
    always_comb begin
        state_nxt = state;
        miss_ack  = 1'b0;
        case (state)
            IDLE: begin
                miss_ack = miss_req;
                if (miss_req) state_nxt = REQ;
            end
            REQ: begin
                if (flush)        state_nxt = mem_gnt ? DRAIN : IDLE;
                else if (mem_gnt) state_nxt = WAIT;
            end
            WAIT: begin
                // a response landing together with flush is already consumed
                if (flush)           state_nxt = mem_rvalid ? IDLE : DRAIN;
                else if (mem_rvalid) state_nxt = (cnt_q == 2'd3) ? FILL : REQ;
            end
            FILL: begin
                if (flush || fill_ready) state_nxt = IDLE;
            end
            DRAIN: begin
                if (mem_rvalid) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // miss context, word buffer and the early critical-word pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_q        <= '0;
            set_q        <= '0;
            start_q      <= '0;
            cnt_q        <= '0;
            buf_q        <= '0;
            crit_valid_q <= 1'b0;
            crit_data_q  <= '0;
        end else begin
            crit_valid_q <= capture && (cnt_q == 2'd0);
            if (accept) begin
                tag_q   <= miss_addr[31:8];
                set_q   <= miss_addr[7:4];
                start_q <= miss_addr[3:2];
                cnt_q   <= 2'd0;
            end
            if (capture) begin
                buf_q[slot] <= mem_rdata;
                if (cnt_q == 2'd0) crit_data_q <= mem_rdata;
                if (cnt_q != 2'd3) cnt_q <= cnt_q + 2'd1;
            end
        end
    end

    assign busy       = (state != IDLE);
    assign mem_req    = (state == REQ);
    assign mem_addr   = (state == REQ) ? {tag_q, set_q, slot, 2'b00} : '0;
    assign crit_valid = crit_valid_q;
    assign crit_data  = crit_data_q;
    assign fill_valid = (state == FILL);
    assign fill_set   = (state == FILL) ? set_q : '0;
    assign fill_line  = (state == FILL) ? entry : '0;

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Bench for cache_refill_ctrl: a transaction-level refill model checked every
// cycle, a configurable memory responder, and directed miss scenarios.
module tb_cache_refill_ctrl;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         miss_req;
    logic [31:0]  miss_addr;
    logic         miss_ack;
    logic         busy;
    logic         flush;
    logic         mem_req;
    logic [31:0]  mem_addr;
    logic         mem_gnt;
    logic         mem_rvalid;
    logic [31:0]  mem_rdata;
    logic         crit_valid;
    logic [31:0]  crit_data;
    logic         fill_valid;
    logic [3:0]   fill_set;
    logic [152:0] fill_line;
    logic         fill_ready;

    cache_refill_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .miss_req   (miss_req),
        .miss_addr  (miss_addr),
        .miss_ack   (miss_ack),
        .busy       (busy),
        .flush      (flush),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .crit_valid (crit_valid),
        .crit_data  (crit_data),
        .fill_valid (fill_valid),
        .fill_set   (fill_set),
        .fill_line  (fill_line),
        .fill_ready (fill_ready)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [152:0] act, input logic [152:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: wait expired at %0t", name, $time);
    endtask

    // ---------------- memory responder ----------------
    int          gnt_stall = 0;
    int          rv_lat    = 1;
    logic [31:0] data_key  = 32'h0;
    bit          inject    = 1'b0;
    int          remaining = 0;
    int          stall_cnt = 0;
    bit          mem_hs;
    logic [31:0] hs_addr;
    logic [31:0] pend_addr;

    initial begin
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        forever begin
            @(negedge clk);
            mem_hs  = mem_req && mem_gnt && rst_n;
            hs_addr = mem_addr;
            @(posedge clk);
            #2;
            mem_rvalid = 1'b0;
            if (mem_hs) begin
                remaining = rv_lat;
                pend_addr = hs_addr;
                stall_cnt = 0;
            end
            if (remaining > 0) begin
                remaining--;
                if (remaining == 0) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = pend_addr ^ data_key;
                end
            end
            if (inject && !mem_rvalid) begin
                mem_rvalid = 1'b1;
                mem_rdata  = 32'hDEAD_BEEF;
                inject     = 1'b0;
            end
            mem_gnt = 1'b0;
            if (mem_req && remaining == 0) begin
                if (stall_cnt >= gnt_stall) mem_gnt = 1'b1;
                else                        stall_cnt++;
            end else begin
                stall_cnt = 0;
            end
        end
    end

    // ---------------- refill model ----------------
    bit          m_busy, m_out, m_drain, m_crit_pend;
    int          m_k, m_start;
    logic [23:0] m_tag;
    logic [3:0]  m_set;
    logic [31:0] m_words [4];
    logic [31:0] m_crit_data;
    bit          exp_req, exp_fill;

    function automatic logic [31:0] req_addr(input int k);
        return {m_tag, m_set, 4'h0} + 32'(((m_start + k) % 4) * 4);
    endfunction

    task automatic model_clear();
        m_busy      = 1'b0;
        m_out       = 1'b0;
        m_drain     = 1'b0;
        m_crit_pend = 1'b0;
        m_k         = 0;
    endtask

    task automatic model_step();
        m_crit_pend = 1'b0;
        if (!m_busy) begin
            if (miss_req) begin
                m_busy  = 1'b1;
                m_k     = 0;
                m_out   = 1'b0;
                m_drain = 1'b0;
                m_tag   = miss_addr[31:8];
                m_set   = miss_addr[7:4];
                m_start = int'(miss_addr[3:2]);
            end
        end else if (m_drain) begin
            if (mem_rvalid) m_busy = 1'b0;
        end else if (flush) begin
            if (exp_req && mem_gnt)      m_drain = 1'b1;
            else if (m_out && !mem_rvalid) m_drain = 1'b1;
            else                         m_busy  = 1'b0;
        end else if (exp_req && mem_gnt) begin
            m_out = 1'b1;
            m_k++;
        end else if (m_out && mem_rvalid) begin
            m_words[(m_start + m_k - 1) % 4] = mem_rdata;
            if (m_k == 1) begin
                m_crit_pend = 1'b1;
                m_crit_data = mem_rdata;
            end
            m_out = 1'b0;
        end else if (exp_fill && fill_ready) begin
            m_busy = 1'b0;
        end
    endtask

    // ---------------- per-cycle compare and event log ----------------
    int           cyc = 0;
    int           acc_cnt = 0, acc_cyc = 0, req_hs = 0, crit_cyc = 0;
    int           fill_seen = 0, fill_hs = 0, fill_hs_cyc = 0;
    logic [31:0]  last_crit;
    logic [152:0] last_fill_line;
    logic [3:0]   last_fill_set;
    logic [31:0]  addr_log [$];

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) model_clear();
        exp_req  = m_busy && !m_drain && !m_out && (m_k < 4);
        exp_fill = m_busy && !m_drain && !m_out && (m_k == 4);
        chk("busy", busy, m_busy);
        chk("miss_ack", miss_ack, !m_busy && miss_req);
        chk("mem_req", mem_req, exp_req);
        if (exp_req) chk("mem_addr", mem_addr, req_addr(m_k));
        chk("crit_valid", crit_valid, m_crit_pend);
        if (m_crit_pend) chk("crit_data", crit_data, m_crit_data);
        chk("fill_valid", fill_valid, exp_fill);
        if (exp_fill) begin
            chk("fill_set", fill_set, m_set);
            chk("fill_line", fill_line,
                {1'b1, m_tag, m_words[3], m_words[2], m_words[1], m_words[0]});
        end
        if (rst_n) begin
            if (miss_req && miss_ack) begin acc_cnt++; acc_cyc = cyc; end
            if (mem_req && mem_gnt) begin req_hs++; addr_log.push_back(mem_addr); end
            if (crit_valid) begin crit_cyc = cyc; last_crit = crit_data; end
            if (fill_valid) fill_seen++;
            if (fill_valid && fill_ready) begin
                fill_hs++;
                fill_hs_cyc    = cyc;
                last_fill_line = fill_line;
                last_fill_set  = fill_set;
            end
            model_step();
        end
    end

    // ---------------- stimulus helpers (called at posedge + 1) ----------------
    task automatic start_miss(input logic [31:0] a);
        miss_req  = 1'b1;
        miss_addr = a;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (miss_ack) begin
                @(posedge clk); #1;
                miss_req = 1'b0;
                return;
            end
        end
        timeout_fail("miss_ack_wait");
        @(posedge clk); #1;
        miss_req = 1'b0;
    endtask

    task automatic wait_idle(input int max_cyc);
        for (int i = 0; i < max_cyc; i++) begin
            if (!busy) return;
            @(posedge clk); #1;
        end
        timeout_fail("idle_wait");
    endtask

    task automatic wait_req_hs(input int target);
        for (int i = 0; i < 200; i++) begin
            if (req_hs >= target) return;
            @(posedge clk); #1;
        end
        timeout_fail("grant_wait");
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_miss_ack"}, miss_ack, 1'b0);
        chk({tag, "_mem_req"}, mem_req, 1'b0);
        chk({tag, "_mem_addr"}, mem_addr, 32'h0);
        chk({tag, "_crit_valid"}, crit_valid, 1'b0);
        chk({tag, "_crit_data"}, crit_data, 32'h0);
        chk({tag, "_fill_valid"}, fill_valid, 1'b0);
        chk({tag, "_fill_set"}, fill_set, 4'h0);
        chk({tag, "_fill_line"}, fill_line, 153'h0);
    endtask

    // ---------------- directed scenarios ----------------
    int base_a, base_b, base_c;
    bit seen;

    initial begin
        rst_n = 1'b1; miss_req = 1'b0; miss_addr = '0; flush = 1'b0; fill_ready = 1'b1;
        #1 rst_n = 1'b0;
        #2 check_all_zero("reset");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // zero-wait memory, data equals address, start offset 1
        addr_log.delete();
        start_miss(32'h0001_0024);
        wait_idle(100);
        chk("t1_nreq", addr_log.size(), 4);
        chk("t1_addr0", addr_log[0], 32'h0001_0024);
        chk("t1_addr1", addr_log[1], 32'h0001_0028);
        chk("t1_addr2", addr_log[2], 32'h0001_002C);
        chk("t1_addr3", addr_log[3], 32'h0001_0020);
        chk("t1_crit_lat", crit_cyc - acc_cyc, 3);
        chk("t1_crit_data", last_crit, 32'h0001_0024);
        chk("t1_fill_lat", fill_hs_cyc - acc_cyc, 9);
        chk("t1_fill_set", last_fill_set, 4'd2);
        chk("t1_valid", last_fill_line[152], 1'b1);
        chk("t1_tag", last_fill_line[151:128], 24'h000100);
        chk("t1_word1", last_fill_line[63:32], 32'h0001_0024);
        chk("t1_word0", last_fill_line[31:0], 32'h0001_0020);

        // grant stalled 3 cycles per request, fill_ready low for 4 FILL cycles
        gnt_stall = 3; fill_ready = 1'b0;
        addr_log.delete(); base_a = fill_hs; base_b = fill_seen;
        start_miss(32'h0005_0A18);
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(posedge clk); #1;
            seen = fill_valid;
        end
        if (!seen) timeout_fail("t2_fill_wait");
        repeat (4) @(posedge clk);
        #1 fill_ready = 1'b1;
        wait_idle(20);
        chk("t2_nreq", addr_log.size(), 4);
        chk("t2_fill_hs", fill_hs - base_a, 1);
        chk("t2_fill_cycles", fill_seen - base_b, 5);
        chk("t2_fill_set", last_fill_set, 4'd1);
        chk("t2_word2", last_fill_line[95:64], 32'h0005_0A18);
        chk("t2_word0", last_fill_line[31:0], 32'h0005_0A10);
        gnt_stall = 0;

        // miss held through an active refill, accepted right after fill_ready
        base_a = acc_cnt; base_b = fill_hs;
        miss_req = 1'b1; miss_addr = 32'h0000_1000;
        for (int i = 0; i < 50 && acc_cnt < base_a + 1; i++) begin @(posedge clk); #1; end
        miss_addr = 32'h0000_2048;
        for (int i = 0; i < 100 && acc_cnt < base_a + 2; i++) begin @(posedge clk); #1; end
        miss_req = 1'b0;
        chk("t3_accepts", acc_cnt - base_a, 2);
        chk("t3_back2back", acc_cyc - fill_hs_cyc, 1);
        wait_idle(100);
        chk("t3_fills", fill_hs - base_b, 2);
        chk("t3_word2", last_fill_line[95:64], 32'h0000_2048);

        // flush in WAIT after the 2nd grant, response 2 cycles later
        rv_lat = 3; base_a = req_hs; base_b = fill_seen;
        start_miss(32'h0000_3030);
        wait_req_hs(base_a + 2);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("t4_drain_busy", busy, 1'b1);
        wait_idle(20);
        chk("t4_no_fill", fill_seen - base_b, 0);
        chk("t4_nreq", req_hs - base_a, 2);
        rv_lat = 1;
        start_miss(32'h0000_4044);
        wait_idle(100);
        chk("t4_refill_set", last_fill_set, 4'd4);
        chk("t4_refill_w0", last_fill_line[31:0], 32'h0000_4040);
        chk("t4_refill_w1", last_fill_line[63:32], 32'h0000_4044);

        // asynchronous reset in WAIT, late response afterwards
        rv_lat = 3; base_a = req_hs;
        start_miss(32'h0000_5050);
        wait_req_hs(base_a + 1);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1 check_all_zero("t5_async");
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("t5_idle", busy, 1'b0);
        chk("t5_crit_data", crit_data, 32'h0);
        rv_lat = 1;

        // spurious rvalid in IDLE and REQ, start offset 3 wrap order
        inject = 1'b1;
        repeat (2) @(posedge clk);
        #1 chk("t6_idle_busy", busy, 1'b0);
        gnt_stall = 2; data_key = 32'hA5A5_0000;
        addr_log.delete();
        start_miss(32'hABCD_E5FE);
        inject = 1'b1;
        wait_idle(100);
        chk("t6_nreq", addr_log.size(), 4);
        chk("t6_addr0", addr_log[0], 32'hABCD_E5FC);
        chk("t6_addr1", addr_log[1], 32'hABCD_E5F0);
        chk("t6_addr2", addr_log[2], 32'hABCD_E5F4);
        chk("t6_addr3", addr_log[3], 32'hABCD_E5F8);
        chk("t6_set", last_fill_set, 4'hF);
        chk("t6_tag", last_fill_line[151:128], 24'hABCDE5);
        chk("t6_word3", last_fill_line[127:96], 32'hABCD_E5FC ^ 32'hA5A5_0000);
        chk("t6_word0", last_fill_line[31:0], 32'hABCD_E5F0 ^ 32'hA5A5_0000);
        gnt_stall = 0; data_key = 32'h0;

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish by %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/cache_refill_ctrl.md
Name: cache_refill_ctrl

Overview:
- Miss-handling stage directly downstream of the data cache.
- On a read miss it fetches the 4-word line containing the missed address from the word-wide main-memory port, critical word first.
- Forwards the critical word early, then hands a complete cache entry (valid, tag, 4 words) to the cache for a single-cycle array write.
- One miss in flight; the cache stalls on busy.

Parameters:
- ADDR_WIDTH, 32, byte address width
- DATA_WIDTH, 32, word width
- CACHE_ADDRESS_WIDTH, 4, set index width (A[7:4])
- TAG_WIDTH, 24, tag width (A[31:8])
- CACHE_DATA_WIDTH, 153, entry width: {valid, tag, w3, w2, w1, w0}

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- miss_req  in  1  cache reports read miss
- miss_addr  in  ADDR_WIDTH  byte address of missed access
- miss_ack  out  1  miss accepted this cycle
- busy  out  1  refill in progress; cache holds pipeline
- flush  in  1  synchronous cancel of current refill
- mem_req  out  1  word read request
- mem_addr  out  ADDR_WIDTH  word-aligned request address
- mem_gnt  in  1  memory accepts mem_req this cycle
- mem_rvalid  in  1  read data valid
- mem_rdata  in  DATA_WIDTH  read data
- crit_valid  out  1  one-cycle pulse: critical word available
- crit_data  out  DATA_WIDTH  critical word
- fill_valid  out  1  complete entry available
- fill_set  out  CACHE_ADDRESS_WIDTH  target set
- fill_line  out  CACHE_DATA_WIDTH  {1'b1, tag, w3, w2, w1, w0}
- fill_ready  in  1  cache writes the entry this cycle

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n: it asserts immediately, with no clock edge needed, and releases on a clk edge.
- Reset values: state IDLE. All outputs 0: miss_ack, busy, mem_req, mem_addr, crit_valid, crit_data, fill_valid, fill_set, fill_line. Word buffer cleared.
- States:
  - IDLE: miss_ack = miss_req (combinational, IDLE only). On acceptance, latch tag = miss_addr[31:8], set = miss_addr[7:4], start = miss_addr[3:2]; cnt = 0; go to REQ.
  - REQ: mem_req = 1, mem_addr = {tag, set, start+cnt (mod 4), 2'b00}. Stay until mem_gnt, then go to WAIT.
  - WAIT: mem_rvalid stores mem_rdata into buffer slot start+cnt (mod 4).
    - If cnt == 0, also register crit_data and pulse crit_valid for the next cycle.
    - If cnt == 3, go to FILL; otherwise cnt++ and go to REQ.
  - FILL: fill_valid = 1, fill_line and fill_set stable. On fill_ready, go to IDLE.
  - DRAIN: swallow exactly one mem_rvalid, then go to IDLE. Outputs remain 0.
- busy = (state != IDLE).
- Memory contract: mem_rvalid arrives at least 1 cycle after mem_gnt. Any mem_rvalid seen outside WAIT/DRAIN is ignored. Only one request is outstanding at a time.
- Latency, with mem_gnt tied high and rvalid one cycle after grant:
  - accept at cycle 0, mem_req at cycle 1;
  - crit_valid at cycle 3;
  - fill_valid at cycle 9.
- miss_req while busy: not acknowledged; the cache must hold the request.
- flush (has priority over all other events):
  - from REQ or FILL: go to IDLE next cycle;
  - from WAIT: go to DRAIN;
  - flush in the same cycle as mem_gnt: go to DRAIN;
  - flush in the same cycle as fill_ready: entry is not considered written; go to IDLE.
  - No fill_valid is ever produced for a flushed refill.
- Ordering: miss_req in the cycle after returning to IDLE is accepted (back-to-back refills).
- Block offset: wrap-around is mod 4. A start of 3 fetches words 3, 0, 1, 2. The byte offset of miss_addr is discarded.
- fill_line word positions are by block offset, independent of fetch order.
- Reset mid-refill: everything is cleared; a late mem_rvalid after reset is ignored (state IDLE).

Decomposition:
- Shared package riscv_cache_pkg holds:
  - width constants (ADDR, DATA, TAG, CACHE_ADDRESS, CACHE_DATA);
  - a refill_state_t enum {IDLE, REQ, WAIT, FILL, DRAIN};
  - a packed cache_entry_t struct {valid, tag, word[3:0]}, which the cache module also uses.
- No sub-module: a single FSM plus a 4-word buffer.

Test Plan:
- Miss at 0x00010024 (start = 1), zero-wait memory returning data = address:
  - mem_addr sequence 0x10024, 0x10028, 0x1002C, 0x10020;
  - crit_data = 0x10024 at cycle 3;
  - fill_valid at cycle 9 with fill_set = 2, tag 0x000100, fill_line word1 = 0x10024.
- Grant stalled 3 cycles on each request, fill_ready held low 4 cycles:
  - mem_addr and fill_line stable throughout;
  - exactly 4 requests;
  - single fill handshake.
- miss_req held during an active refill: miss_ack stays 0 until IDLE, then the second miss is accepted the cycle after fill_ready.
- flush in WAIT after the 2nd grant, with the response arriving 2 cycles later:
  - DRAIN absorbs the response, then IDLE;
  - no fill_valid;
  - a new miss is then serviced correctly.
- rst_n pulsed low mid-WAIT: all outputs 0 asynchronously; a spurious mem_rvalid afterwards changes nothing.
- Spurious mem_rvalid in IDLE/REQ is ignored, and a start = 3 wrap gives the fetch order 3, 0, 1, 2.
